// File: rtl/cpu_pkg.sv
// Shared encodings for the datapath: ALU ops, operand-B shifts, sequencer states
// and the captured instruction word.
package cpu_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned REG_W  = 3;
  localparam int unsigned FLAG_W = 3;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_CMP = 2'b01,
    OP_AND = 2'b10,
    OP_MVN = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL1 = 2'b01,
    SH_LSR1 = 2'b10,
    SH_ASR1 = 2'b11
  } sh_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RDA  = 3'd1,
    ST_RDB  = 3'd2,
    ST_EXEC = 3'd3,
    ST_WB   = 3'd4
  } state_e;

  typedef struct packed {
    op_e              op;
    sh_e              sh;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rn;
    logic [REG_W-1:0] rm;
  } instr_t;

  // Single-bit operand-B shifter; LSR fills with zero, ASR replicates the sign.
  function automatic logic [DATA_W-1:0] shift_b(input logic [DATA_W-1:0] b, input sh_e sh);
    logic [DATA_W-1:0] r;
    case (sh)
      SH_LSL1: r = {b[DATA_W-2:0], 1'b0};
      SH_LSR1: r = {1'b0, b[DATA_W-1:1]};
      SH_ASR1: r = {b[DATA_W-1], b[DATA_W-1:1]};
      default: r = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu16.sv
// Combinational shifter + ALU + {N,V,Z} flag generation for the sequencer.
module alu16
  import cpu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        op,
  input  logic [1:0]        sh,
  output logic [DATA_W-1:0] result_c,
  output logic [FLAG_W-1:0] status_c
);

  logic [DATA_W-1:0] bsh;
  logic              v;

  always_comb begin
    bsh      = shift_b(b, sh_e'(sh));
    result_c = '0;
    v        = 1'b0;
    case (op_e'(op))
      OP_ADD: begin
        result_c = a + bsh;
        v        = (a[DATA_W-1] == bsh[DATA_W-1]) && (result_c[DATA_W-1] != a[DATA_W-1]);
      end
      OP_CMP: begin
        result_c = a - bsh;
        v        = (a[DATA_W-1] != bsh[DATA_W-1]) && (result_c[DATA_W-1] != a[DATA_W-1]);
      end
      OP_AND:  result_c = a & bsh;
      default: result_c = ~bsh;
    endcase
    status_c = {result_c[DATA_W-1], v, (result_c == '0)};
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU sequencer: reads A and B from an external register file,
// executes, and writes back, one instruction every five cycles.
module alu_sequencer
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [1:0]  sh,
  input  logic [2:0]  rd,
  input  logic [2:0]  rn,
  input  logic [2:0]  rm,
  output logic [2:0]  rf_readnum,
  input  logic [15:0] rf_data_out,
  output logic [2:0]  rf_writenum,
  output logic        rf_write,
  output logic [15:0] rf_data_in,
  output logic [2:0]  status,
  output logic        done
);

  state_e            state;
  instr_t            instr;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] c_q;
  logic              wr_q;
  logic              done_q;
  logic [DATA_W-1:0] alu_res;
  logic [FLAG_W-1:0] alu_status;

  alu16 u_alu (
    .a        (a_q),
    .b        (b_q),
    .op       (instr.op),
    .sh       (instr.sh),
    .result_c (alu_res),
    .status_c (alu_status)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      instr       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      status      <= '0;
      rf_writenum <= '0;
      rf_readnum  <= '0;
      wr_q        <= 1'b0;
      done_q      <= 1'b0;
      in_ready    <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            instr.op   <= op_e'(op);
            instr.sh   <= sh_e'(sh);
            instr.rd   <= rd;
            instr.rn   <= rn;
            instr.rm   <= rm;
            rf_readnum <= rn;
            in_ready   <= 1'b0;
            state      <= ST_RDA;
          end
        end
        ST_RDA: begin
          a_q        <= rf_data_out;
          rf_readnum <= instr.rm;
          state      <= ST_RDB;
        end
        ST_RDB: begin
          b_q        <= rf_data_out;
          rf_readnum <= '0;
          state      <= ST_EXEC;
        end
        ST_EXEC: begin
          c_q         <= alu_res;
          status      <= alu_status;
          rf_writenum <= instr.rd;
          wr_q        <= (instr.op != OP_CMP);
          done_q      <= 1'b1;
          state       <= ST_WB;
        end
        ST_WB: begin
          wr_q     <= 1'b0;
          done_q   <= 1'b0;
          in_ready <= 1'b1;
          state    <= ST_IDLE;
        end
        default: begin
          wr_q       <= 1'b0;
          done_q     <= 1'b0;
          rf_readnum <= '0;
          in_ready   <= 1'b1;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

  // The register file samples the write port on the same edge that sees reset,
  // so a reset during WB has to kill the strobe before that edge.
  assign rf_write   = wr_q & ~reset;
  assign done       = done_q & ~reset;
  assign rf_data_in = c_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with an 8x16 register-file model.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [1:0]  sh;
  logic [2:0]  rd;
  logic [2:0]  rn;
  logic [2:0]  rm;
  logic [2:0]  rf_readnum;
  logic [15:0] rf_data_out;
  logic [2:0]  rf_writenum;
  logic        rf_write;
  logic [15:0] rf_data_in;
  logic [2:0]  status;
  logic        done;

  logic [15:0] rf [8];
  logic        tb_we;
  logic [2:0]  tb_wa;
  logic [15:0] tb_wd;

  int checks = 0;
  int errors = 0;

  alu_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
    .sh          (sh),
    .rd          (rd),
    .rn          (rn),
    .rm          (rm),
    .rf_readnum  (rf_readnum),
    .rf_data_out (rf_data_out),
    .rf_writenum (rf_writenum),
    .rf_write    (rf_write),
    .rf_data_in  (rf_data_in),
    .status      (status),
    .done        (done)
  );

  always #5 clk = ~clk;

  assign rf_data_out = rf[rf_readnum];

  always @(posedge clk) begin
    if (rf_write)   rf[rf_writenum] <= rf_data_in;
    else if (tb_we) rf[tb_wa]       <= tb_wd;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rf_load(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    tb_we = 1'b1;
    tb_wa = a;
    tb_wd = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  // Offers one instruction at the first idle cycle and returns at the negedge
  // of the cycle in which done is seen (or when the cycle budget runs out).
  task automatic issue(input logic [1:0] o, input logic [1:0] s, input logic [2:0] d,
                       input logic [2:0] n, input logic [2:0] m, input logic exp_wr);
    int lat;
    int guard;
    bit got;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_accept", 16'(in_ready), 16'h1);
    in_valid = 1'b1;
    op = o; sh = s; rd = d; rn = n; rm = m;
    @(posedge clk);
    #1;
    // Scramble fields after accept so capture is exercised.
    op = ~o; sh = ~s; rd = ~d; rn = ~n; rm = ~m;
    lat = 1;
    got = 1'b0;
    while (!got && lat < 10) begin
      @(negedge clk);
      if (done) got = 1'b1;
      else begin
        check("in_ready_busy", 16'(in_ready), 16'h0);
        check("rf_write_outside_wb", 16'(rf_write), 16'h0);
        if (lat == 1) check("readnum_rda", 16'(rf_readnum), 16'(n));
        if (lat == 2) check("readnum_rdb", 16'(rf_readnum), 16'(m));
        if (lat == 3) check("readnum_exec", 16'(rf_readnum), 16'h0);
        if (lat == 2) in_valid = 1'b0;
        @(posedge clk);
        lat++;
      end
    end
    in_valid = 1'b0;
    check("done_latency", 16'(lat), 16'd4);
    check("in_ready_wb", 16'(in_ready), 16'h0);
    check("readnum_wb", 16'(rf_readnum), 16'h0);
    check("rf_write_wb", 16'(rf_write), 16'(exp_wr));
    check("rf_writenum_wb", 16'(rf_writenum), 16'(d));
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; op = '0; sh = '0; rd = '0; rn = '0; rm = '0;
    tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 16'(in_ready), 16'h1);
    check("rst_done", 16'(done), 16'h0);
    check("rst_rf_write", 16'(rf_write), 16'h0);
    check("rst_status", 16'(status), 16'h0);
    check("rst_readnum", 16'(rf_readnum), 16'h0);
    check("rst_writenum", 16'(rf_writenum), 16'h0);
    check("rst_data_in", rf_data_in, 16'h0);

    // ADD R3 = R1 + R2
    rf_load(3'd1, 16'h0003);
    rf_load(3'd2, 16'h0005);
    issue(2'b00, 2'b00, 3'd3, 3'd1, 3'd2, 1'b1);
    check("add_data_in_wb", rf_data_in, 16'h0008);
    @(negedge clk);
    check("add_r3", rf[3], 16'h0008);
    check("add_status", 16'(status), 16'h0000);
    check("hold_data_in", rf_data_in, 16'h0008);
    check("hold_writenum", 16'(rf_writenum), 16'h3);
    check("idle_rf_write", 16'(rf_write), 16'h0);

    // ADD overflow into the sign bit
    rf_load(3'd1, 16'h7FFF);
    rf_load(3'd2, 16'h0001);
    issue(2'b00, 2'b00, 3'd4, 3'd1, 3'd2, 1'b1);
    @(negedge clk);
    check("addv_r4", rf[4], 16'h8000);
    check("addv_status", 16'(status), 16'b110);

    // CMP equal operands: no writeback
    rf_load(3'd1, 16'h0005);
    rf_load(3'd2, 16'h0005);
    issue(2'b01, 2'b00, 3'd3, 3'd1, 3'd2, 1'b0);
    @(negedge clk);
    check("cmp_r3_unchanged", rf[3], 16'h0008);
    check("cmp_status", 16'(status), 16'b001);

    // MVN of ASR1(0x8002) = ~0xC001
    rf_load(3'd2, 16'h8002);
    issue(2'b11, 2'b11, 3'd5, 3'd1, 3'd2, 1'b1);
    @(negedge clk);
    check("mvn_r5", rf[5], 16'h3FFE);
    check("mvn_status", 16'(status), 16'b000);

    // rd == rn == rm with LSL1: R1 = 5 + 10
    issue(2'b00, 2'b01, 3'd1, 3'd1, 3'd1, 1'b1);
    @(negedge clk);
    check("lsl_r1", rf[1], 16'h000F);
    check("lsl_status", 16'(status), 16'b000);

    // AND with LSR1: 0x000F & 0x4001
    issue(2'b10, 2'b10, 3'd0, 3'd1, 3'd2, 1'b1);
    @(negedge clk);
    check("lsr_r0", rf[0], 16'h0001);

    // Back-to-back dependent pair
    rf_load(3'd1, 16'h00FF);
    rf_load(3'd2, 16'h0001);
    issue(2'b00, 2'b00, 3'd3, 3'd1, 3'd2, 1'b1);
    issue(2'b10, 2'b00, 3'd6, 3'd3, 3'd1, 1'b1);
    @(negedge clk);
    check("b2b_r3", rf[3], 16'h0100);
    check("b2b_r6", rf[6], 16'h0000);
    check("b2b_status", 16'(status), 16'b001);

    // Reset during WB of ADD R7 = R1 + R1 (would set V and Z)
    rf_load(3'd1, 16'h8000);
    rf_load(3'd7, 16'h1234);
    @(negedge clk);
    in_valid = 1'b1; op = 2'b00; sh = 2'b00; rd = 3'd7; rn = 3'd1; rm = 3'd1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("abort_done", 16'(done), 16'h0);
    check("abort_rf_write", 16'(rf_write), 16'h0);
    check("abort_status_pre", 16'(status), 16'b011);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_r7", rf[7], 16'h1234);
    check("abort_in_ready", 16'(in_ready), 16'h1);
    check("abort_status", 16'(status), 16'h0);
    check("abort_data_in", rf_data_in, 16'h0);
    check("abort_writenum", 16'(rf_writenum), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
